// File: rtl/snes_pad_reader_pkg.sv
// Shared definitions for the serial game-pad front end: button bit positions
// in the published vector and the pad protocol FSM state encoding.
package snes_pad_reader_pkg;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } pad_state_e;

  // Shift register holds active-low bits in wire order A,B,Sel,Start,U,D,L,R.
  function automatic logic [7:0] wire_to_buttons(input logic [7:0] sr);
    logic [7:0] b;
    b             = '0;
    b[BTN_A]      = ~sr[0];
    b[BTN_B]      = ~sr[1];
    b[BTN_SELECT] = ~sr[2];
    b[BTN_START]  = ~sr[3];
    b[BTN_UP]     = ~sr[4];
    b[BTN_DOWN]   = ~sr[5];
    b[BTN_LEFT]   = ~sr[6];
    b[BTN_RIGHT]  = ~sr[7];
    return b;
  endfunction

endpackage

// File: rtl/snes_pad_reader_sync.sv
// Single-bit multi-flop synchronizer for asynchronous pad and switch inputs.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    ff[0] <= d;
    for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/snes_pad_reader.sv
// NES/SNES-style pad reader: latch pulse, eight shift clocks, then publishes an
// active-high button snapshot with newly-pressed pulses.
module snes_pad_reader
  import snes_pad_reader_pkg::*;
#(
  parameter int LATCH_CYCLES = 1200,
  parameter int HALF_CYCLES  = 600,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid,
  output logic       busy
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  pad_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sr, sr_n;
  logic             pending, pending_n;
  logic             data_s;
  logic             phase_end;
  logic [7:0]       snap;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .d   (pad_data),
    .q   (data_s)
  );

  assign phase_end = (cnt == CNT_ONE);
  assign snap      = wire_to_buttons(sr);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    sr_n      = sr;
    pending_n = pending;
    // A poll arriving mid-transaction (DONE included) is remembered once.
    if (poll && state != ST_IDLE) pending_n = 1'b1;
    case (state)
      ST_IDLE: begin
        if (poll || pending) begin
          state_n   = ST_LATCH;
          cnt_n     = LATCH_LOAD;
          pending_n = 1'b0;
        end
      end
      ST_LATCH: begin
        if (phase_end) begin
          state_n = ST_LOW;
          cnt_n   = HALF_LOAD;
          idx_n   = 3'd0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          sr_n[idx] = data_s;
          state_n   = ST_HIGH;
          cnt_n     = HALF_LOAD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          if (idx == 3'd7) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = ST_LOW;
            cnt_n   = HALF_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ST_DONE: begin
        pending_n = 1'b0;
        if (pending || poll) begin
          state_n = ST_LATCH;
          cnt_n   = LATCH_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pad strobes are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sr        <= '0;
      pending   <= 1'b0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      buttons   <= '0;
      pressed   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sr        <= sr_n;
      pending   <= pending_n;
      pad_latch <= (state_n == ST_LATCH);
      pad_clk   <= (state_n != ST_LOW);
      busy      <= (state_n != ST_IDLE);
      valid     <= (state == ST_DONE);
      if (state == ST_DONE) begin
        buttons <= snap;
        pressed <= snap & ~buttons;
      end else begin
        pressed <= '0;
      end
    end
  end

endmodule
